// File: rtl/id_operand_queue.sv
// id_operand_queue: FWFT instruction queue between IFU and EXU with priority operand
// forwarding, hazard-gated issue, flush, occupancy and a saturating stall counter.
module id_operand_queue #(
    parameter int IBUF_DEPTH = 4,
    parameter int NUM_FWD    = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [31:0]                       in_pc,
    input  logic [31:0]                       in_inst,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [31:0]                       out_pc,
    output logic [31:0]                       out_inst,
    output logic [31:0]                       out_rj_value,
    output logic [31:0]                       out_rkd_value,
    output logic [4:0]                        rf_raddr1,
    output logic [4:0]                        rf_raddr2,
    input  logic [31:0]                       rf_rdata1,
    input  logic [31:0]                       rf_rdata2,
    input  logic [NUM_FWD-1:0]                fwd_valid,
    input  logic [NUM_FWD-1:0]                fwd_we,
    input  logic [NUM_FWD-1:0]                fwd_data_ok,
    input  logic [5*NUM_FWD-1:0]              fwd_dest,
    input  logic [32*NUM_FWD-1:0]             fwd_data,
    output logic [$clog2(IBUF_DEPTH+1)-1:0]   occupancy,
    output logic [31:0]                       stall_cycles
);
    localparam int PW = $clog2(IBUF_DEPTH);
    localparam int CW = $clog2(IBUF_DEPTH+1);

    logic [31:0]   pc_q   [IBUF_DEPTH];
    logic [31:0]   inst_q [IBUF_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   stall_q, stall_d;
    logic          push, pop, not_empty, hazard;
    logic [5:0]    op;
    logic          use_rj, use_rkd, src_is_rd, rj_ok, rkd_ok;
    logic [4:0]    dest;

    always_comb begin
        not_empty     = count_q != '0;
        in_ready      = count_q != CW'(IBUF_DEPTH);
        out_pc        = pc_q[rd_ptr_q];
        out_inst      = inst_q[rd_ptr_q];
        op            = out_inst[31:26];
        use_rj        = !(op == 6'h14 || op == 6'h15 || op == 6'h05 || op == 6'h07);
        src_is_rd     = op == 6'h16 || op == 6'h17 || (op == 6'h0a && out_inst[25:22] == 4'd6);
        use_rkd       = src_is_rd || (op == 6'h00 && out_inst[25:22] == 4'd0);
        rf_raddr1     = out_inst[9:5];
        rf_raddr2     = src_is_rd ? out_inst[4:0] : out_inst[14:10];
        out_rj_value  = rf_rdata1;
        out_rkd_value = rf_rdata2;
        rj_ok         = 1'b1;
        rkd_ok        = 1'b1;
        dest          = '0;
        // Walk oldest to youngest so the lowest matching stage overrides the rest.
        for (int i = NUM_FWD-1; i >= 0; i--) begin
            dest = fwd_dest[5*i +: 5];
            if (fwd_valid[i] && fwd_we[i] && dest != 5'd0 && dest == rf_raddr1 && use_rj) begin
                out_rj_value = fwd_data[32*i +: 32];
                rj_ok        = fwd_data_ok[i];
            end
            if (fwd_valid[i] && fwd_we[i] && dest != 5'd0 && dest == rf_raddr2 && use_rkd) begin
                out_rkd_value = fwd_data[32*i +: 32];
                rkd_ok        = fwd_data_ok[i];
            end
        end
        hazard    = !rj_ok || !rkd_ok;
        out_valid = not_empty && !hazard && !flush;
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready;
        wr_ptr_d  = flush ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d  = flush ? '0 : rd_ptr_q + PW'(pop);
        count_d   = flush ? '0 : count_q + CW'(push) - CW'(pop);
        stall_d   = (not_empty && hazard && !flush && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;
        occupancy    = count_q;
        stall_cycles = stall_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Storage needs no reset; count gates every use of its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr_q]   <= in_pc;
            inst_q[wr_ptr_q] <= in_inst;
        end
    end
endmodule

// File: tb/tb_id_operand_queue.sv
// tb_id_operand_queue: directed scenario tasks with inline checks against
// hand-computed values for the operand queue.
module tb_id_operand_queue;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_pc, in_inst, out_pc, out_inst, out_rj_value, out_rkd_value;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [2:0]  fwd_valid, fwd_we, fwd_data_ok;
    logic [14:0] fwd_dest;
    logic [95:0] fwd_data;
    logic [2:0]  occupancy;
    logic [31:0] stall_cycles;
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDW = 32'h0010_0823;

    id_operand_queue #(.IBUF_DEPTH(4), .NUM_FWD(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rj_value(out_rj_value), .out_rkd_value(out_rkd_value),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .fwd_valid(fwd_valid), .fwd_we(fwd_we),
        .fwd_data_ok(fwd_data_ok), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        fwd_valid = '0; fwd_we = '0; fwd_data_ok = '1; fwd_dest = '0; fwd_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 0; in_pc = 0; in_inst = ADDW; flush = 0; out_ready = 0;
        rf_rdata1 = 32'hAAAA; rf_rdata2 = 32'hBBBB;
        clear_fwd();
        #12 reset = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
    endtask

    task automatic test_stream();
        out_ready = 1;
        for (int k = 0; k <= 8; k++) begin
            in_valid = (k < 8);
            in_pc    = 32'h1000 + 32'(4*k);
            #1;
            if (k == 0) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle got %b exp 0", out_valid); end
            end else begin
                checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1000 + 32'(4*(k-1)))
                    begin errors++; $display("FAIL stream_issue k=%0d got v=%b pc=%h exp v=1 pc=%h", k, out_valid, out_pc, 32'h1000 + 32'(4*(k-1))); end
                checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL stream_occ k=%0d got %0d exp 1", k, occupancy); end
            end
            step();
        end
        in_valid = 0;
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL stream_end_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_full_wrap();
        logic [31:0] exp_q[$];
        int pushed = 0;
        int issued = 0;
        logic do_push, do_pop;
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; in_pc = 32'h2000 + 32'(4*k);
            step();
            exp_q.push_back(in_pc);
        end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL full_occ got %0d exp 4", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        in_pc = 32'hDEAD;
        step();
        checks++; if (occupancy !== 3'd4 || out_pc !== 32'h2000)
            begin errors++; $display("FAIL full_refuse got occ=%0d pc=%h exp occ=4 pc=2000", occupancy, out_pc); end
        out_ready = 1;
        for (int cyc = 0; cyc < 40 && issued < 10; cyc++) begin
            in_valid = (pushed < 6);
            in_pc    = 32'h2000 + 32'(4*(4+pushed));
            #1;
            checks++; if (in_ready !== (exp_q.size() != 4))
                begin errors++; $display("FAIL wrap_in_ready cyc=%0d got %b exp %b", cyc, in_ready, exp_q.size() != 4); end
            checks++; if (out_valid !== (exp_q.size() != 0))
                begin errors++; $display("FAIL wrap_out_valid cyc=%0d got %b exp %b", cyc, out_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                checks++; if (out_pc !== exp_q[0]) begin errors++; $display("FAIL wrap_order cyc=%0d got %h exp %h", cyc, out_pc, exp_q[0]); end
            end
            do_pop  = exp_q.size() != 0;
            do_push = in_valid && exp_q.size() != 4;
            step();
            if (do_pop) begin void'(exp_q.pop_front()); issued++; end
            if (do_push) begin exp_q.push_back(in_pc); pushed++; end
        end
        in_valid = 0;
        checks++; if (issued != 10 || occupancy !== 3'd0)
            begin errors++; $display("FAIL wrap_total got issued=%0d occ=%0d exp 10/0", issued, occupancy); end
    endtask

    task automatic test_forwarding();
        out_ready = 0; in_valid = 1; in_pc = 32'h3000; in_inst = ADDW;
        step();
        in_valid = 0;
        fwd_valid = '1; fwd_we = '1; fwd_data_ok = '1;
        fwd_dest = {5'd1, 5'd2, 5'd1};
        fwd_data = {32'h33, 32'h22, 32'h11};
        #1;
        checks++; if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2)
            begin errors++; $display("FAIL fwd_raddr got %0d/%0d exp 1/2", rf_raddr1, rf_raddr2); end
        checks++; if (out_rj_value !== 32'h11 || out_rkd_value !== 32'h22 || out_valid !== 1'b1)
            begin errors++; $display("FAIL fwd_priority got rj=%h rkd=%h v=%b exp 11/22/1", out_rj_value, out_rkd_value, out_valid); end
        fwd_valid = 3'b110; #1;
        checks++; if (out_rj_value !== 32'h33) begin errors++; $display("FAIL fwd_older got %h exp 33", out_rj_value); end
        fwd_valid = '1; fwd_data_ok = 3'b110; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwd_young_not_ok got %b exp 0", out_valid); end
        fwd_data_ok = '1; fwd_dest = '0; #1;
        checks++; if (out_rj_value !== 32'hAAAA || out_rkd_value !== 32'hBBBB)
            begin errors++; $display("FAIL fwd_rf got rj=%h rkd=%h exp AAAA/BBBB", out_rj_value, out_rkd_value); end
        out_ready = 1; step();
        in_valid = 1; in_inst = 32'h5800_00E9; in_pc = 32'h3004; out_ready = 0; clear_fwd();
        step();
        in_valid = 0; #1;
        checks++; if (rf_raddr1 !== 5'd7 || rf_raddr2 !== 5'd9)
            begin errors++; $display("FAIL beq_raddr got %0d/%0d exp 7/9", rf_raddr1, rf_raddr2); end
        out_ready = 1; step();
        in_valid = 1; in_inst = 32'h5000_0020; in_pc = 32'h3008; out_ready = 0;
        step();
        in_valid = 0;
        fwd_valid = 3'b001; fwd_we = 3'b001; fwd_data_ok = 3'b000; fwd_dest = {10'd0, 5'd1};
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b_no_rj_hazard got %b exp 1", out_valid); end
        out_ready = 1; step();
        clear_fwd();
    endtask

    task automatic test_load_use();
        logic [31:0] s0;
        out_ready = 0; in_valid = 1; in_pc = 32'h4000; in_inst = 32'h0010_00A6;
        fwd_valid = 3'b001; fwd_we = 3'b001; fwd_data_ok = 3'b000;
        fwd_dest = {10'd0, 5'd5}; fwd_data = {64'd0, 32'h55};
        #1 s0 = stall_cycles;
        step();
        in_valid = 0; out_ready = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL loaduse_stall c=%0d got %b exp 0", c, out_valid); end
            step();
        end
        fwd_data_ok = 3'b001; #1;
        checks++; if (stall_cycles !== s0 + 32'd2) begin errors++; $display("FAIL loaduse_count got %0d exp %0d", stall_cycles, s0 + 32'd2); end
        checks++; if (out_valid !== 1'b1 || out_rj_value !== 32'h55 || out_pc !== 32'h4000)
            begin errors++; $display("FAIL loaduse_issue got v=%b rj=%h pc=%h exp 1/55/4000", out_valid, out_rj_value, out_pc); end
        step();
        clear_fwd();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL loaduse_pop got %0d exp 0", occupancy); end
    endtask

    task automatic test_flush();
        logic [31:0] s0;
        out_ready = 0; in_inst = ADDW;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; in_pc = 32'h5000 + 32'(4*k);
            step();
        end
        s0 = stall_cycles;
        in_pc = 32'h5FFF; flush = 1; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle_valid got %b exp 0", out_valid); end
        step();
        flush = 0; in_valid = 0; #1;
        checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL flush_empty got occ=%0d v=%b exp 0/0", occupancy, out_valid); end
        step();
        checks++; if (occupancy !== 3'd0 || stall_cycles !== s0)
            begin errors++; $display("FAIL flush_discard got occ=%0d stall=%0d exp 0/%0d", occupancy, stall_cycles, s0); end
    endtask

    task automatic test_async_reset();
        out_ready = 0; in_valid = 1; in_pc = 32'h6000;
        step(); step();
        in_valid = 0;
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 3'd0 || stall_cycles !== 32'd0)
            begin errors++; $display("FAIL async_reset got v=%b rdy=%b occ=%0d stall=%0d exp 0/1/0/0", out_valid, in_ready, occupancy, stall_cycles); end
        step();
        reset = 1'b0;
        step();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL async_reset_hold got %0d exp 0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_wrap();
        test_forwarding();
        test_load_use();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
